// File: rtl/if_prefetch_buffer.sv
// RV32 instruction-fetch prefetch buffer: issues imem word fetches, queues {instr, pc}, flushes on redirect.
// Define IF_PREFETCH_BYPASS_EN to forward a response straight to out_* when the queue is empty.
module if_prefetch_buffer #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] boot_addr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus_4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          run_q;
    logic          pend_q, pend_d;
    logic          stale_q, stale_d;
    logic [31:0]   pend_addr_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic [CW-1:0] used;
    logic [31:0]   redir_pc;
    logic          issue, gnt_ok, rv_ok, head_v, byp, push, pop;

    // Credit: buffered + live in-flight entries must leave room in the queue.
    assign used     = cnt_q + outst_q - disc_q;
    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
    assign issue    = run_q && !redirect && (outst_q < CW'(MAX_OUTSTANDING)) && (used < CW'(DEPTH));

    assign imem_req  = pend_q | issue;
    assign imem_addr = pend_q ? pend_addr_q : (issue ? fetch_pc_q : 32'h0);
    assign gnt_ok    = imem_req & imem_gnt;
    assign rv_ok     = imem_rvalid & (outst_q != '0);
    assign head_v    = (cnt_q != '0);

`ifdef IF_PREFETCH_BYPASS_EN
    assign byp = rv_ok && !redirect && (cnt_q == '0) && (disc_q == '0) && out_ready;
`else
    assign byp = 1'b0;
`endif

    assign push = rv_ok && !redirect && (disc_q == '0) && !byp;
    assign pop  = head_v && out_ready && !redirect;

    assign out_valid     = head_v | byp;
    assign out_instr     = byp ? imem_rdata : (head_v ? instr_mem[rd_q] : NOP);
    assign out_pc        = byp ? resp_pc_q  : (head_v ? pc_mem[rd_q]    : 32'h0);
    assign out_pc_plus_4 = out_pc + 32'd4;

    assign pend_d = imem_req & ~imem_gnt;

    always_comb begin
        outst_d    = outst_q + CW'(gnt_ok) - CW'(rv_ok);
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        disc_d     = disc_q;
        stale_d    = stale_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        rd_d       = rd_q + AW'(pop);
        wr_d       = wr_q + AW'(push);
        // A held request that outlived a redirect must not advance fetch_pc; its data is dropped.
        if (gnt_ok && !stale_q)        fetch_pc_d = fetch_pc_q + 32'd4;
        if (push || byp)               resp_pc_d  = resp_pc_q + 32'd4;
        if (rv_ok && disc_q != '0)     disc_d     = disc_q - CW'(1);
        if (gnt_ok && stale_q)         disc_d     = disc_d + CW'(1);
        if (gnt_ok)                    stale_d    = 1'b0;
        if (redirect) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            disc_d     = outst_d;
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            stale_d    = pend_q & ~imem_gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q       <= 1'b0;
            pend_q      <= 1'b0;
            stale_q     <= 1'b0;
            pend_addr_q <= 32'h0;
            fetch_pc_q  <= boot_addr & 32'hFFFF_FFFC;
            resp_pc_q   <= boot_addr & 32'hFFFF_FFFC;
            outst_q     <= '0;
            disc_q      <= '0;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
        end else begin
            run_q       <= 1'b1;
            pend_q      <= pend_d;
            stale_q     <= stale_d;
            pend_addr_q <= imem_addr;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            outst_q     <= outst_d;
            disc_q      <= disc_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_q] <= imem_rdata;
            pc_mem[wr_q]    <= resp_pc_q;
        end
    end
endmodule
